// File: rtl/pcpi_mul_if.sv
// PCPI request/response bundle between the CPU core and the multiply sequencer.
// The CPU side is the master; the coprocessor side is the slave.
interface pcpi_mul_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );

  modport slave (
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready
  );
endinterface

// File: rtl/pcpi_mul_ctrl.sv
// Sequencer between the PCPI port and a shift-add multiplier datapath: decodes
// MUL/MULH/MULHSU/MULHU, starts the datapath, returns the result, and guards it with a watchdog.
module pcpi_mul_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 80,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  pcpi_mul_if.slave            pcpi,
  output logic [31:0]          mul_rs1,
  output logic [31:0]          mul_rs2,
  output logic                 mul_start,
  output logic                 instr_any_mulh,
  output logic                 instr_rs1_signed,
  output logic                 instr_rs2_signed,
  input  logic                 mul_waiting,
  input  logic                 mul_finish,
  input  logic [63:0]          mul_prod,
  output logic                 err_timeout,
  output logic [CNT_WIDTH-1:0] op_count
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BUSY, S_DONE, S_DRAIN} state_e;

  localparam logic [7:0] BUSY_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [7:0]           busy_cnt_q, busy_cnt_d;
  logic                 after_done_q, after_done_d;
  logic [31:0]          rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                 any_mulh_q, any_mulh_d, rs1_signed_q, rs1_signed_d;
  logic                 rs2_signed_q, rs2_signed_d;
  logic                 start_q, start_d, wait_q, wait_d, ready_q, ready_d, err_q, err_d;
  logic [CNT_WIDTH-1:0] op_count_q, op_count_d;

  logic [2:0] funct3;
  logic       is_mul, accept, timeout_hit, unused_insn;

  assign funct3      = pcpi.pcpi_insn[14:12];
  assign is_mul      = (pcpi.pcpi_insn[6:0] == 7'b0110011) &&
                       (pcpi.pcpi_insn[31:25] == 7'b0000001) && !funct3[2];
  // The cycle right after DONE still sees the old request held valid; never re-claim it.
  assign accept      = (state_q == S_IDLE) && pcpi.pcpi_valid && is_mul && !after_done_q;
  assign timeout_hit = (busy_cnt_q >= BUSY_LAST);
  assign unused_insn = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      busy_cnt_q   <= '0;
      after_done_q <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      any_mulh_q   <= 1'b0;
      rs1_signed_q <= 1'b0;
      rs2_signed_q <= 1'b0;
      start_q      <= 1'b0;
      wait_q       <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      op_count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values, order-independent.
      state_q      <= state_d;
      busy_cnt_q   <= busy_cnt_d;
      after_done_q <= after_done_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      any_mulh_q   <= any_mulh_d;
      rs1_signed_q <= rs1_signed_d;
      rs2_signed_q <= rs2_signed_d;
      start_q      <= start_d;
      wait_q       <= wait_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      op_count_q   <= op_count_d;
    end
  end

  // Dropping pcpi_valid abandons the request; the datapath is still allowed to drain.
  always_comb begin
    // NOTE: default assignment first, so no path through the case can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: begin
        if (!pcpi.pcpi_valid) state_d = S_DRAIN;
        else if (mul_waiting) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!pcpi.pcpi_valid) state_d = mul_finish ? S_IDLE : S_DRAIN;
        else if (mul_finish)  state_d = S_DONE;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (mul_finish || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    any_mulh_d   = any_mulh_q;
    rs1_signed_d = rs1_signed_q;
    rs2_signed_d = rs2_signed_q;
    if (accept) begin
      rs1_d        = pcpi.pcpi_rs1;
      rs2_d        = pcpi.pcpi_rs2;
      any_mulh_d   = (funct3 != 3'b000);
      rs1_signed_d = (funct3 == 3'b001) || (funct3 == 3'b010);
      rs2_signed_d = (funct3 == 3'b001);
    end

    busy_cnt_d = '0;
    if (state_q == S_BUSY || state_q == S_DRAIN)
      busy_cnt_d = (busy_cnt_q == 8'hFF) ? busy_cnt_q : busy_cnt_q + 8'd1;

    rd_d = rd_q;
    if (state_q == S_BUSY && state_d == S_DONE)
      rd_d = any_mulh_q ? mul_prod[63:32] : mul_prod[31:0];

    start_d      = (state_q == S_START) && (state_d == S_BUSY);
    wait_d       = (state_d == S_START) || (state_d == S_BUSY);
    ready_d      = (state_d == S_DONE);
    err_d        = timeout_hit && !mul_finish &&
                   ((state_q == S_BUSY && pcpi.pcpi_valid) || state_q == S_DRAIN);
    after_done_d = (state_q == S_DONE);
    op_count_d   = op_count_q + CNT_WIDTH'(state_q == S_DONE);
  end

  assign pcpi.pcpi_wr     = ready_q;
  assign pcpi.pcpi_ready  = ready_q;
  assign pcpi.pcpi_wait   = wait_q;
  assign pcpi.pcpi_rd     = rd_q;
  assign mul_rs1          = rs1_q;
  assign mul_rs2          = rs2_q;
  assign mul_start        = start_q;
  assign instr_any_mulh   = any_mulh_q;
  assign instr_rs1_signed = rs1_signed_q;
  assign instr_rs2_signed = rs2_signed_q;
  assign err_timeout      = err_q;
  assign op_count         = op_count_q;

endmodule

// File: tb/tb_pcpi_mul_ctrl.sv
// Directed bench for pcpi_mul_ctrl with a behavioural shift-add datapath of programmable latency.
// Expected results are hand-computed constants.
module tb_pcpi_mul_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] mul_rs1, mul_rs2;
  logic        mul_start, instr_any_mulh, instr_rs1_signed, instr_rs2_signed;
  logic        mul_waiting;
  logic        mul_finish = 1'b0;
  logic [63:0] mul_prod = '0;
  logic        err_timeout;
  logic [31:0] op_count;

  pcpi_mul_if bus ();

  pcpi_mul_ctrl #(.TIMEOUT_CYCLES(80), .CNT_WIDTH(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .pcpi             (bus),
    .mul_rs1          (mul_rs1),
    .mul_rs2          (mul_rs2),
    .mul_start        (mul_start),
    .instr_any_mulh   (instr_any_mulh),
    .instr_rs1_signed (instr_rs1_signed),
    .instr_rs2_signed (instr_rs2_signed),
    .mul_waiting      (mul_waiting),
    .mul_finish       (mul_finish),
    .mul_prod         (mul_prod),
    .err_timeout      (err_timeout),
    .op_count         (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Datapath model: mul_finish arrives dp_latency cycles after the mul_start cycle.
  logic        dp_busy = 1'b0;
  logic        dp_block, dp_hang;
  int          dp_latency;
  int          dp_left = 0;
  logic [63:0] dp_prod = '0;

  assign mul_waiting = !dp_busy && !dp_block;

  always @(negedge clk) begin
    mul_finish = 1'b0;
    if (!resetn) begin
      dp_busy = 1'b0;
      dp_left = 0;
    end else if (dp_busy) begin
      if (dp_left <= 1) begin
        dp_busy = 1'b0;
        if (!dp_hang) begin
          mul_finish = 1'b1;
          mul_prod   = dp_prod;
        end
      end else begin
        dp_left--;
      end
    end else if (mul_start) begin
      dp_busy = 1'b1;
      dp_left = dp_latency;
      dp_prod = (instr_rs1_signed ? {{32{mul_rs1[31]}}, mul_rs1} : {32'd0, mul_rs1}) *
                (instr_rs2_signed ? {{32{mul_rs2[31]}}, mul_rs2} : {32'd0, mul_rs2});
    end
  end

  int start_pulses = 0, ready_pulses = 0, err_pulses = 0;
  always @(negedge clk) begin
    if (mul_start)      start_pulses++;
    if (bus.pcpi_ready) ready_pulses++;
    if (err_timeout)    err_pulses++;
  end

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Issues one request and follows it to pcpi_ready or err_timeout. Latencies are counted
  // in cycles from the cycle the request is presented (the accept cycle).
  task automatic run_op(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int block, output int start_at, output int end_at,
                        output logic [31:0] rd_seen, output logic wr_seen, output logic err_seen);
    start_at = -1;
    end_at   = -1;
    rd_seen  = '0;
    wr_seen  = 1'b0;
    err_seen = 1'b0;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = insn;
    bus.pcpi_rs1   = rs1;
    bus.pcpi_rs2   = rs2;
    dp_block       = (block > 0);
    for (int n = 1; n <= 300 && end_at < 0; n++) begin
      @(negedge clk);
      if (n == block + 1) dp_block = 1'b0;
      if (mul_start && start_at < 0) start_at = n;
      if (bus.pcpi_ready) begin
        end_at  = n;
        rd_seen = bus.pcpi_rd;
        wr_seen = bus.pcpi_wr;
      end
      if (err_timeout) begin
        end_at   = n;
        err_seen = 1'b1;
      end
    end
    check("op_completes", 64'(end_at >= 0), 1);
    dp_block = 1'b0;
    if (err_seen || end_at < 0) begin
      bus.pcpi_valid = 1'b0;
    end else begin
      // CPU keeps valid up for the cycle after ready; that cycle must not re-claim the request.
      @(negedge clk);
      @(negedge clk);
      check("no_reaccept", bus.pcpi_wait, 0);
      bus.pcpi_valid = 1'b0;
    end
  endtask

  logic [2:0]  t_f3    [4] = '{3'b000, 3'b011, 3'b001, 3'b010};
  logic [31:0] t_rs1   [4] = '{32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] t_rs2   [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
  int          t_lat   [4] = '{34, 3, 1, 12};
  logic [31:0] t_rd    [4] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF};
  logic [2:0]  t_flags [4] = '{3'b000, 3'b100, 3'b111, 3'b110};

  initial begin
    int          s_at, e_at, s0, r0, e0;
    logic [31:0] rd, c0;
    logic        wr, err, seen;
    logic [31:0] div_insn;

    resetn         = 1'b0;
    bus.pcpi_valid = 1'b0;
    bus.pcpi_insn  = '0;
    bus.pcpi_rs1   = '0;
    bus.pcpi_rs2   = '0;
    dp_block       = 1'b0;
    dp_hang        = 1'b0;
    dp_latency     = 34;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr, mul_start, err_timeout}, 0);
    check("rst_rd", bus.pcpi_rd, 0);
    check("rst_op_count", op_count, 0);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      dp_latency = t_lat[i];
      s0 = start_pulses;
      run_op(mk_insn(7'b0000001, t_f3[i]), t_rs1[i], t_rs2[i], 0, s_at, e_at, rd, wr, err);
      check($sformatf("op%0d_start_lat", i), s_at, 2);
      check($sformatf("op%0d_ready_lat", i), e_at, 3 + t_lat[i]);
      check($sformatf("op%0d_rd", i), rd, t_rd[i]);
      check($sformatf("op%0d_wr", i), wr, 1);
      check($sformatf("op%0d_flags", i), {instr_any_mulh, instr_rs1_signed, instr_rs2_signed}, t_flags[i]);
      check($sformatf("op%0d_rs", i), {mul_rs1, mul_rs2}, {t_rs1[i], t_rs2[i]});
      check($sformatf("op%0d_starts", i), start_pulses - s0, 1);
      check($sformatf("op%0d_count", i), op_count, i + 1);
    end

    // DIV and plain ADD are never claimed.
    for (int k = 0; k < 2; k++) begin
      div_insn = (k == 0) ? mk_insn(7'b0000001, 3'b100) : mk_insn(7'b0000000, 3'b000);
      s0 = start_pulses;
      r0 = ready_pulses;
      seen = 1'b0;
      @(negedge clk);
      bus.pcpi_valid = 1'b1;
      bus.pcpi_insn  = div_insn;
      repeat (10) begin
        @(negedge clk);
        seen = seen | bus.pcpi_wait;
      end
      bus.pcpi_valid = 1'b0;
      check($sformatf("unclaimed%0d_wait", k), seen, 0);
      check($sformatf("unclaimed%0d_ready_start", k), {32'(ready_pulses - r0), 32'(start_pulses - s0)}, 0);
    end

    // Datapath not ready for 5 cycles after accept: mul_start moves by exactly 5.
    dp_latency = 4;
    s0 = start_pulses;
    run_op(mk_insn(7'b0000001, 3'b000), 32'd3, 32'd5, 5, s_at, e_at, rd, wr, err);
    check("stall_start_lat", s_at, 7);
    check("stall_ready_lat", e_at, 12);
    check("stall_rd", rd, 32'h0000000F);
    check("stall_starts", start_pulses - s0, 1);
    check("stall_count", op_count, 5);

    // Watchdog: datapath never finishes.
    dp_hang    = 1'b1;
    dp_latency = 10;
    r0 = ready_pulses;
    run_op(mk_insn(7'b0000001, 3'b000), 32'd2, 32'd3, 0, s_at, e_at, rd, wr, err);
    check("to_err", err, 1);
    check("to_lat", e_at, 82);
    check("to_wait", bus.pcpi_wait, 0);
    repeat (2) @(negedge clk);
    check("to_no_ready", ready_pulses - r0, 0);
    check("to_count", op_count, 5);
    dp_hang    = 1'b0;
    dp_latency = 6;
    run_op(mk_insn(7'b0000001, 3'b000), 32'd6, 32'd7, 0, s_at, e_at, rd, wr, err);
    check("after_to_rd", rd, 32'h0000002A);
    check("after_to_err", err, 0);
    check("after_to_count", op_count, 6);

    // Request abandoned mid-BUSY; the finish that follows must not complete it.
    dp_latency = 20;
    r0 = ready_pulses;
    e0 = err_pulses;
    c0 = op_count;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk_insn(7'b0000001, 3'b000);
    bus.pcpi_rs1   = 32'd11;
    bus.pcpi_rs2   = 32'd13;
    repeat (10) @(negedge clk);
    check("drain_wait_busy", bus.pcpi_wait, 1);
    bus.pcpi_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (mul_finish) seen = 1'b1;
    end
    check("drain_finish_seen", seen, 1);
    repeat (3) @(negedge clk);
    check("drain_no_ready", ready_pulses - r0, 0);
    check("drain_no_err", err_pulses - e0, 0);
    check("drain_wait", bus.pcpi_wait, 0);
    check("drain_count", op_count, c0);

    // Asynchronous reset in the middle of BUSY.
    dp_latency = 30;
    @(negedge clk);
    bus.pcpi_valid = 1'b1;
    bus.pcpi_insn  = mk_insn(7'b0000001, 3'b011);
    bus.pcpi_rs1   = 32'd9;
    bus.pcpi_rs2   = 32'd9;
    repeat (10) @(negedge clk);
    check("arst_pre_wait", bus.pcpi_wait, 1);
    resetn = 1'b0;
    #1;
    check("arst_ctrl", {bus.pcpi_wait, bus.pcpi_ready, bus.pcpi_wr, mul_start, err_timeout}, 0);
    check("arst_flags", {instr_any_mulh, instr_rs1_signed, instr_rs2_signed}, 0);
    check("arst_rs", {mul_rs1, mul_rs2}, 0);
    check("arst_rd", bus.pcpi_rd, 0);
    check("arst_count", op_count, 0);
    bus.pcpi_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    dp_latency = 5;
    run_op(mk_insn(7'b0000001, 3'b000), 32'd6, 32'd7, 0, s_at, e_at, rd, wr, err);
    check("post_rst_rd", rd, 32'h0000002A);
    check("post_rst_count", op_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcpi_mul_ctrl.md
Name: pcpi_mul_ctrl

Overview:
Sequencer between the PicoRV32 PCPI port and the shift-add multiplier datapath (the block holding rs1/rs2/rd/rdx, mul_counter, mul_waiting, mul_finish).
- Decodes MUL/MULH/MULHSU/MULHU and captures the operands.
- Drives the datapath's control inputs (mul_start, signedness flags) and waits for completion.
- Selects the result half and completes the PCPI handshake.
- Adds a watchdog timeout and a completed-operation counter.

Parameters:
TIMEOUT_CYCLES, 80, max cycles in BUSY before abort; legal range 1..255.
CNT_WIDTH, 32, width of op_count; wraps modulo 2^CNT_WIDTH.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
pcpi_valid  in  1  CPU request valid, held until pcpi_ready or abandoned
pcpi_insn  in  32  instruction word
pcpi_rs1  in  32  operand 1
pcpi_rs2  in  32  operand 2
pcpi_wr  out  1  result write enable, pulses with pcpi_ready
pcpi_rd  out  32  result
pcpi_wait  out  1  request claimed, in progress
pcpi_ready  out  1  one-cycle completion pulse
mul_rs1  out  32  captured operand 1 to datapath
mul_rs2  out  32  captured operand 2 to datapath
mul_start  out  1  start strobe to datapath
instr_any_mulh  out  1  high-half op (funct3 != 000)
instr_rs1_signed  out  1  MULH or MULHSU
instr_rs2_signed  out  1  MULH only
mul_waiting  in  1  datapath idle and ready for start
mul_finish  in  1  datapath done pulse
mul_prod  in  64  datapath product (rd)
err_timeout  out  1  one-cycle pulse on watchdog abort
op_count  out  CNT_WIDTH  completed-operation count

Behaviour:
Reset: while resetn is low, all outputs are 0, state is IDLE, busy counter is 0 and op_count is 0. Reset takes effect immediately, including mid-operation; no ready pulse is emitted.

Decode:
- A request is a mul op when pcpi_insn[6:0]==7'b0110011 and [31:25]==7'b0000001 and [14:12] is in 000..011.
- funct3 100..111 (DIV/REM) and all other instructions are never claimed: the block stays IDLE with pcpi_wait=0.

State machine (all outputs registered):
IDLE:
- Accepts when pcpi_valid is high and the instruction is a mul op, except in the first cycle after DONE.
- On accept: capture rs1, rs2 and the three flags; set pcpi_wait=1 from the next cycle; go to START.
START:
- mul_start=1 while mul_waiting=1 (asserted for one cycle); then go to BUSY with busy counter = 0.
- If mul_waiting=0, stay in START with mul_start=0.
BUSY:
- Busy counter increments each cycle, saturating at its maximum value.
- On mul_finish: pcpi_rd = instr_any_mulh ? mul_prod[63:32] : mul_prod[31:0]; go to DONE.
- If pcpi_valid is low while in BUSY or START: go to DRAIN.
- If the counter reaches TIMEOUT_CYCLES with no finish: err_timeout=1 for one cycle, pcpi_wait=0, go to IDLE.
- mul_finish takes priority over timeout in the same cycle.
DONE (one cycle):
- pcpi_ready=1, pcpi_wr=1, pcpi_wait=0; op_count increments.
- Go to IDLE.
DRAIN:
- pcpi_wait=0, no ready pulse.
- Go to IDLE on mul_finish or on timeout; err_timeout pulses only in the timeout case.

Latency: accept to pcpi_ready = 3 + datapath latency. The datapath latency is the number of cycles from mul_start to mul_finish.

Other rules:
- pcpi_rd holds its value until the next completion.
- mul_rs1/mul_rs2 are stable from START until the next accept.

Test Plan:
- MUL, rs1=32'h00000007, rs2=32'hFFFFFFFD, bench datapath model with 34-cycle latency -> instr flags 0/0/0, one mul_start pulse, pcpi_ready/pcpi_wr pulse with pcpi_rd=32'hFFFFFFEB, op_count=1.
- MULHU, rs1=rs2=32'hFFFFFFFF -> instr_any_mulh=1, both signed flags 0, pcpi_rd=32'hFFFFFFFE. MULH with the same operands -> rs1/rs2 signed=1/1, pcpi_rd=32'h00000000. MULHSU, rs1=32'hFFFFFFFF, rs2=32'h00000002 -> signed flags 1/0, pcpi_rd=32'hFFFFFFFF.
- DIV instruction (funct3=100) held valid for 10 cycles -> pcpi_wait, pcpi_ready and mul_start all stay 0.
- mul_waiting held low for 5 cycles after accept -> mul_start delayed exactly 5 cycles, still a single pulse.
- Datapath never finishes, TIMEOUT_CYCLES=80 -> err_timeout pulse after 80 BUSY cycles, pcpi_wait=0, no pcpi_ready, op_count unchanged; next MUL request is accepted normally.
- pcpi_valid dropped mid-BUSY, then mul_finish arrives -> no pcpi_ready, back in IDLE. Separately, resetn low mid-BUSY -> all outputs 0 immediately, asynchronously.
